// File: rtl/iter_divider_if.sv
// ---------------------------------------------------------------------------
// iter_divider_if
//   Operand/result bus between the EXE stage and the iterative divider.
//
//   Request side : in_valid, in_ready, in_signed, dividend, divisor
//   Flush        : cancel
//   Response side: out_valid, out_ready, quotient, remainder, div_by_zero
//   Status       : busy
//
//   master : the EXE stage (drives operands, out_ready and cancel)
//   slave  : the divider   (drives in_ready, results and status)
// ---------------------------------------------------------------------------
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid,
    output in_signed,
    output dividend,
    output divisor,
    output cancel,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_signed,
    input  dividend,
    input  divisor,
    input  cancel,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero,
    output busy
  );
endinterface

// File: rtl/iter_divider.sv
// ---------------------------------------------------------------------------
// iter_divider
//   Multi-cycle restoring integer divider (signed and unsigned) returning
//   quotient and remainder together with a fixed, data-independent latency.
//
//   Parameters
//     WIDTH : operand/result width (even, >= 4)
//     BPC   : quotient bits retired per cycle (1, 2 or 4; divides WIDTH)
//
//   Ports
//     clk   : clock, rising edge
//     reset : asynchronous active-low reset
//     bus   : iter_divider_if slave modport
//             in_valid/in_ready handshake accepts operands (in_ready only
//             in IDLE); out_valid/out_ready hands back quotient, remainder
//             and div_by_zero; cancel flushes any state back to IDLE;
//             busy is high whenever the unit is not IDLE.
//
//   Flow: IDLE -> CALC (WIDTH/BPC cycles) -> FIX -> DONE -> IDLE
//         IDLE -> FIX directly on a zero divisor.
// ---------------------------------------------------------------------------
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic          clk,
  input  logic          reset,
  iter_divider_if.slave bus
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CNT_W = $clog2(STEPS + 1);

  // Reject illegal configurations at elaboration time.
  if (((WIDTH % 2) != 0) || (WIDTH < 4) ||
      !((BPC == 1) || (BPC == 2) || (BPC == 4)) || ((WIDTH % BPC) != 0)) begin : g_bad_param
    $error("iter_divider: illegal WIDTH/BPC combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // Magnitude of a value; only signed operands with the sign bit set are
  // negated, so unsigned operands with MSB set pass through untouched.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] val,
                                                 input logic             is_signed);
    logic [WIDTH-1:0] res_s;
    if (is_signed && val[WIDTH-1]) begin
      res_s = -val;
    end else begin
      res_s = val;
    end
    return res_s;
  endfunction

  // Two's complement negate when neg is set (mod 2^WIDTH).
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] val,
                                                   input logic             neg);
    logic [WIDTH-1:0] res_s;
    if (neg) begin
      res_s = -val;
    end else begin
      res_s = val;
    end
    return res_s;
  endfunction

  // One restoring step. The shifted partial remainder is WIDTH+1 bits wide;
  // once the trial subtraction succeeds the true difference is below the
  // divisor, so a WIDTH-bit subtraction yields it exactly.
  // Returns {new partial remainder, new quotient shift register}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] rem_s;
    logic             qbit_s;
    shifted_s = {rem, quo[WIDTH-1]};
    if (shifted_s >= {1'b0, dvs}) begin
      rem_s  = shifted_s[WIDTH-1:0] - dvs;
      qbit_s = 1'b1;
    end else begin
      rem_s  = shifted_s[WIDTH-1:0];
      qbit_s = 1'b0;
    end
    return {rem_s, quo[WIDTH-2:0], qbit_s};
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;        // partial remainder
  logic [WIDTH-1:0] quo_q;        // quotient shift register / raw dividend on dz
  logic [WIDTH-1:0] dvs_q;        // divisor magnitude
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dz_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_by_zero_q;

  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             accept_s;
  logic             divisor_zero_s;

  assign accept_s       = bus.in_valid && (state_q == IDLE);
  assign divisor_zero_s = (bus.divisor == {WIDTH{1'b0}});

  // BPC chained restoring steps per CALC cycle.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    for (int i = 0; i < BPC; i++) begin
      {rem_d, quo_d} = div_step(rem_d, quo_d, dvs_q);
    end
  end

  // Control FSM with registered result outputs; cancel overrides every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      rem_q         <= {WIDTH{1'b0}};
      quo_q         <= {WIDTH{1'b0}};
      dvs_q         <= {WIDTH{1'b0}};
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      dz_q          <= 1'b0;
      out_valid_q   <= 1'b0;
      quotient_q    <= {WIDTH{1'b0}};
      remainder_q   <= {WIDTH{1'b0}};
      div_by_zero_q <= 1'b0;
    end else if (bus.cancel) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            q_neg_q <= bus.in_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg_q <= bus.in_signed & bus.dividend[WIDTH-1];
            dz_q    <= divisor_zero_s;
            dvs_q   <= magnitude(bus.divisor, bus.in_signed);
            rem_q   <= {WIDTH{1'b0}};
            cnt_q   <= CNT_W'(STEPS - 1);
            if (divisor_zero_s) begin
              // Keep the unmodified dividend; it is returned as the remainder.
              quo_q   <= bus.dividend;
              state_q <= FIX;
            end else begin
              quo_q   <= magnitude(bus.dividend, bus.in_signed);
              state_q <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end

        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_q <= FIX;
          end else begin
            state_q <= CALC;
          end
        end

        FIX: begin
          if (dz_q) begin
            quotient_q    <= {WIDTH{1'b1}};
            remainder_q   <= quo_q;
            div_by_zero_q <= 1'b1;
          end else begin
            quotient_q    <= cond_negate(quo_q, q_neg_q);
            remainder_q   <= cond_negate(rem_q, r_neg_q);
            div_by_zero_q <= 1'b0;
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // in_ready and busy depend on the state register only.
  assign bus.in_ready    = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_iter_divider.sv
// ---------------------------------------------------------------------------
// tb_iter_divider
//   Bench for iter_divider. Two instances share the stimulus bus: dut1
//   (WIDTH=32, BPC=1) and dut4 (WIDTH=32, BPC=4); `sel` picks which one
//   receives in_valid and whose outputs are observed. Expected results come
//   from plain 64-bit arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_iter_divider;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        in_valid;
  logic        in_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        out_ready;

  logic        ov;
  logic        ir;
  logic        bsy;
  logic        dzo;
  logic [31:0] quo;
  logic [31:0] rem;

  int vecs;
  int errs;

  iter_divider_if #(.WIDTH(32)) b1 ();
  iter_divider_if #(.WIDTH(32)) b4 ();

  assign b1.in_valid  = in_valid & ~sel;
  assign b4.in_valid  = in_valid & sel;
  assign b1.in_signed = in_signed;
  assign b4.in_signed = in_signed;
  assign b1.dividend  = dividend;
  assign b4.dividend  = dividend;
  assign b1.divisor   = divisor;
  assign b4.divisor   = divisor;
  assign b1.cancel    = cancel;
  assign b4.cancel    = cancel;
  assign b1.out_ready = out_ready;
  assign b4.out_ready = out_ready;

  assign ov  = sel ? b4.out_valid   : b1.out_valid;
  assign ir  = sel ? b4.in_ready    : b1.in_ready;
  assign bsy = sel ? b4.busy        : b1.busy;
  assign dzo = sel ? b4.div_by_zero : b1.div_by_zero;
  assign quo = sel ? b4.quotient    : b1.quotient;
  assign rem = sel ? b4.remainder   : b1.remainder;

  iter_divider #(.WIDTH(32), .BPC(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  iter_divider #(.WIDTH(32), .BPC(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division on sign- or zero-extended 64-bit values.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end
  endfunction

  // One full transaction with latency, result, hold-stability and handoff checks.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int gap, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    int          exp_lat;
    int          n;
    ref_div(sgn, a, b, eq, er, edz);
    exp_lat = edz ? 2 : ((sel ? 8 : 32) + 2);

    vecs++;
    if (ir !== 1'b1) begin
      $display("FAIL %s in_ready_before: got %b want 1", tag, ir);
      errs++;
    end

    in_valid  = 1'b1;
    in_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk); #1;
    n = 1;
    in_valid  = 1'b0;
    in_signed = 1'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
    while (ov !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end

    vecs++;
    if (ov !== 1'b1) begin
      $display("FAIL %s timeout: out_valid never rose within %0d cycles", tag, n);
      errs++;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      return;
    end
    vecs++;
    if (n !== exp_lat) begin
      $display("FAIL %s latency: got %0d want %0d", tag, n, exp_lat);
      errs++;
    end
    vecs++;
    if (quo !== eq || rem !== er || dzo !== edz) begin
      $display("FAIL %s result: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
               tag, quo, rem, dzo, eq, er, edz);
      errs++;
    end

    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      in_signed = 1'($urandom);
      dividend  = $urandom;
      divisor   = $urandom;
      vecs++;
      if (ov !== 1'b1 || quo !== eq || rem !== er || dzo !== edz || ir !== 1'b0 || bsy !== 1'b1) begin
        $display("FAIL %s hold%0d: got ov=%b q=%h r=%h dz=%b ir=%b busy=%b want ov=1 q=%h r=%h dz=%b ir=0 busy=1",
                 tag, i, ov, quo, rem, dzo, ir, bsy, eq, er, edz);
        errs++;
      end
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vecs++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      $display("FAIL %s handoff: got ov=%b ir=%b want ov=0 ir=1", tag, ov, ir);
      errs++;
    end
  endtask

  // Watch a window of cycles and report whether out_valid ever rose.
  task automatic expect_quiet(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ov === 1'b1) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0) begin
      $display("FAIL %s quiet: out_valid rose, want none", tag);
      errs++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      vecs++;
      if (ov !== 1'b0 || quo !== 32'd0 || rem !== 32'd0 || dzo !== 1'b0 || bsy !== 1'b0 || ir !== 1'b1) begin
        $display("FAIL reset_state sel=%0d: got ov=%b q=%h r=%h dz=%b busy=%b ir=%b want 0/0/0/0/0/1",
                 s, ov, quo, rem, dzo, bsy, ir);
        errs++;
      end
    end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    sel = 1'b0;
    run_op(1'b0, 32'd100,        32'd7,        0, "u100_7");
    run_op(1'b1, 32'hFFFF_FFF9,  32'd2,        0, "s-7_2");
    run_op(1'b1, 32'd7,          32'hFFFF_FFFE, 0, "s7_-2");
    run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 0, "s_min_-1");
    run_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 0, "u_min_max");
    run_op(1'b1, 32'h0000_1234,  32'd0,        0, "s_dz");
    run_op(1'b0, 32'h0000_1234,  32'd0,        0, "u_dz");
    run_op(1'b0, 32'hFFFF_FFFF,  32'd1,        0, "u_max_1");
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    run_op(1'b1, 32'hFFFF_FF9C, 32'd9, 10, "bp_s");
    sel = 1'b1;
    run_op(1'b0, 32'hDEAD_BEEF, 32'd0, 10, "bp_dz");
  endtask

  task automatic test_cancel();
    sel = 1'b0;
    // Flush in the middle of CALC.
    in_valid = 1'b1; in_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    vecs++;
    if (bsy !== 1'b0 || ov !== 1'b0 || ir !== 1'b1) begin
      $display("FAIL cancel_calc: got busy=%b ov=%b ir=%b want 0/0/1", bsy, ov, ir);
      errs++;
    end
    expect_quiet(40, "cancel_calc");
    run_op(1'b0, 32'd9, 32'd3, 0, "after_cancel");

    // Cancel together with in_valid in IDLE: nothing is accepted.
    in_valid = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0; cancel = 1'b0;
    vecs++;
    if (bsy !== 1'b0 || ir !== 1'b1) begin
      $display("FAIL cancel_idle: got busy=%b ir=%b want 0/1", bsy, ir);
      errs++;
    end
    expect_quiet(40, "cancel_idle");

    // Cancel together with out_ready in DONE drops the result.
    sel = 1'b1;
    in_valid = 1'b1; in_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 30 && ov !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    vecs++;
    if (ov !== 1'b1) begin
      $display("FAIL cancel_done_setup: got ov=%b want 1", ov);
      errs++;
    end
    cancel = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0; out_ready = 1'b0;
    vecs++;
    if (ov !== 1'b0 || ir !== 1'b1 || bsy !== 1'b0) begin
      $display("FAIL cancel_done: got ov=%b ir=%b busy=%b want 0/1/0", ov, ir, bsy);
      errs++;
    end
    run_op(1'b1, 32'hFFFF_FFCE, 32'd5, 0, "after_cancel_done");
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    run_op(1'b0, 32'd9, 32'd3, 0, "pre_reset");
    in_valid = 1'b1; in_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2;
    reset = 1'b0;
    #1;
    vecs++;
    if (quo !== 32'd0 || rem !== 32'd0 || ov !== 1'b0 || bsy !== 1'b0 || ir !== 1'b1) begin
      $display("FAIL reset_mid: got q=%h r=%h ov=%b busy=%b ir=%b want 0/0/0/0/1", quo, rem, ov, bsy, ir);
      errs++;
    end
    @(negedge clk);
    reset = 1'b1;
    expect_quiet(40, "reset_mid");
    run_op(1'b0, 32'd100, 32'd7, 0, "after_reset");
  endtask

  task automatic test_random();
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          mode;
    sel = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      sgn  = 1'($urandom);
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 15));
        4: b = {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 31'($urandom_range(0, 255))};
        default: ;
      endcase
      run_op(sgn, a, b, $urandom_range(0, 3), "rand");
    end
  endtask

  initial begin
    vecs      = 0;
    errs      = 0;
    sel       = 1'b0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    cancel    = 1'b0;
    out_ready = 1'b0;

    test_reset();
    test_directed();
    test_backpressure();
    test_cancel();
    test_reset_mid();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
